// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module : traffic_pkg
// Desc   : Shared state encoding, lamp codes and default dwell times.
// Rev    : 1.0
// ============================================================================
package traffic_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam int DEF_Y2R_DELAY = 3;
  localparam int DEF_R2G_DELAY = 2;
  localparam int DEF_CNT_W     = 4;

endpackage
`default_nettype wire

// File: rtl/traffic_timer.sv
`default_nettype none
// ============================================================================
// Module : traffic_timer
// Desc   : Dwell counter with clear/enable; done flags the last cycle of a dwell.
// Rev    : 1.0
// ============================================================================
module traffic_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last = i_limit - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_done = i_en && (r_count == w_last);

endmodule
`default_nettype wire

// File: rtl/traffic.sv
`default_nettype none
// ============================================================================
// Module : traffic
// Desc   : NS/EW intersection controller; EW sensor X requests a timed change.
// Rev    : 1.0
// ============================================================================
module traffic
  import traffic_pkg::*;
#(
  parameter int Y2R_DELAY = DEF_Y2R_DELAY,
  parameter int R2G_DELAY = DEF_R2G_DELAY,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       X,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light
);

  state_t           r_state;
  state_t           w_next;
  logic             w_timed;
  logic             w_done;
  logic             w_clr;
  logic [CNT_W-1:0] w_limit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter is held at zero outside timed states and restarts on every change.
  assign w_clr = (w_next != r_state) || !w_timed;

  traffic_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clock),
    .rst_n   (reset),
    .i_clr   (w_clr),
    .i_en    (w_timed),
    .i_limit (w_limit),
    .o_done  (w_done)
  );

  always_comb begin
    w_next   = r_state;
    w_timed  = 1'b0;
    w_limit  = '0;
    ns_light = GREEN;
    ew_light = RED;
    case (r_state)
      S0: begin
        if (X) w_next = S1;
      end
      S1: begin
        w_timed  = 1'b1;
        w_limit  = CNT_W'(Y2R_DELAY);
        ns_light = YELLOW;
        if (w_done) w_next = S2;
      end
      S2: begin
        w_timed  = 1'b1;
        w_limit  = CNT_W'(R2G_DELAY);
        ns_light = RED;
        if (w_done) w_next = S3;
      end
      S3: begin
        ns_light = RED;
        ew_light = GREEN;
        if (!X) w_next = S4;
      end
      S4: begin
        w_timed  = 1'b1;
        w_limit  = CNT_W'(Y2R_DELAY);
        ns_light = RED;
        ew_light = YELLOW;
        if (w_done) w_next = S0;
      end
      default: begin
        w_next = S0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic.sv
`default_nettype none
// ============================================================================
// Module : tb_traffic
// Desc   : Directed self-checking bench for the traffic controller.
// Rev    : 1.0
// ============================================================================
module tb_traffic;

  localparam logic [1:0] L_R = 2'd0;
  localparam logic [1:0] L_Y = 2'd1;
  localparam logic [1:0] L_G = 2'd2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       X     = 1'b0;
  logic [1:0] ns_light;
  logic [1:0] ew_light;

  int checks = 0;
  int errors = 0;

  // Expected lights after edges n..n+9 of one default-parameter change cycle.
  logic [1:0] seq_ns [0:9] = '{L_Y, L_Y, L_Y, L_R, L_R, L_R, L_R, L_R, L_R, L_G};
  logic [1:0] seq_ew [0:9] = '{L_R, L_R, L_R, L_R, L_R, L_G, L_Y, L_Y, L_Y, L_R};

  traffic dut (
    .clock    (clock),
    .reset    (reset),
    .X        (X),
    .ns_light (ns_light),
    .ew_light (ew_light)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b0;
    X     = 1'b1;
    #1;
    checks++;
    if (ns_light !== L_G || ew_light !== L_R) begin
      errors++;
      $display("FAIL reset_immediate ns=%0d ew=%0d expected ns=2 ew=0", ns_light, ew_light);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (ns_light !== L_G || ew_light !== L_R) begin
        errors++;
        $display("FAIL reset_held[%0d] ns=%0d ew=%0d expected ns=2 ew=0", k, ns_light, ew_light);
      end
    end
    reset = 1'b1;
    X     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (ns_light !== L_G || ew_light !== L_R) begin
        errors++;
        $display("FAIL reset_release[%0d] ns=%0d ew=%0d expected ns=2 ew=0", k, ns_light, ew_light);
      end
    end
  endtask

  task automatic test_full_cycle();
    for (int k = 0; k < 10; k++) begin
      X = (k < 6);
      tick();
      checks++;
      if (ns_light !== seq_ns[k] || ew_light !== seq_ew[k]) begin
        errors++;
        $display("FAIL full_cycle[n+%0d] ns=%0d ew=%0d expected ns=%0d ew=%0d",
                 k, ns_light, ew_light, seq_ns[k], seq_ew[k]);
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 11; k++) begin
      logic [1:0] ens;
      logic [1:0] eew;
      X   = (k == 0) || (k == 2) || (k == 4);
      ens = (k < 10) ? seq_ns[k] : L_G;
      eew = (k < 10) ? seq_ew[k] : L_R;
      tick();
      checks++;
      if (ns_light !== ens || ew_light !== eew) begin
        errors++;
        $display("FAIL glitch[n+%0d] ns=%0d ew=%0d expected ns=%0d ew=%0d",
                 k, ns_light, ew_light, ens, eew);
      end
    end
  endtask

  task automatic test_ew_hold();
    for (int k = 0; k < 44; k++) begin
      logic [1:0] ens;
      logic [1:0] eew;
      X = (k < 40);
      if (k < 5) begin
        ens = seq_ns[k];
        eew = seq_ew[k];
      end else if (k < 40) begin
        ens = L_R;
        eew = L_G;
      end else if (k < 43) begin
        ens = L_R;
        eew = L_Y;
      end else begin
        ens = L_G;
        eew = L_R;
      end
      tick();
      checks++;
      if (ns_light !== ens || ew_light !== eew) begin
        errors++;
        $display("FAIL ew_hold[n+%0d] ns=%0d ew=%0d expected ns=%0d ew=%0d",
                 k, ns_light, ew_light, ens, eew);
      end
    end
  endtask

  task automatic test_async_reset_mid_s2();
    for (int k = 0; k < 5; k++) begin
      X = (k == 0);
      tick();
    end
    checks++;
    if (ns_light !== L_R || ew_light !== L_R) begin
      errors++;
      $display("FAIL pre_reset_s2 ns=%0d ew=%0d expected ns=0 ew=0", ns_light, ew_light);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ns_light !== L_G || ew_light !== L_R) begin
      errors++;
      $display("FAIL async_reset_s2 ns=%0d ew=%0d expected ns=2 ew=0", ns_light, ew_light);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (ns_light !== L_G || ew_light !== L_R) begin
      errors++;
      $display("FAIL post_reset_idle ns=%0d ew=%0d expected ns=2 ew=0", ns_light, ew_light);
    end
    for (int k = 0; k < 10; k++) begin
      X = (k < 6);
      tick();
      checks++;
      if (ns_light !== seq_ns[k] || ew_light !== seq_ew[k]) begin
        errors++;
        $display("FAIL after_reset[n+%0d] ns=%0d ew=%0d expected ns=%0d ew=%0d",
                 k, ns_light, ew_light, seq_ns[k], seq_ew[k]);
      end
    end
  endtask

  task automatic test_random_safety();
    for (int i = 0; i < 1000; i++) begin
      X = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ((ns_light !== L_R && ew_light !== L_R) || ns_light === 2'd3 || ew_light === 2'd3) begin
        errors++;
        $display("FAIL safety[%0d] ns=%0d ew=%0d expected at least one RED and no code 3",
                 i, ns_light, ew_light);
      end
      if ($urandom_range(0, 49) == 0) begin
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (ns_light !== L_G || ew_light !== L_R) begin
          errors++;
          $display("FAIL random_reset[%0d] ns=%0d ew=%0d expected ns=2 ew=0", i, ns_light, ew_light);
        end
        #1;
        reset = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_glitch();
    test_ew_hold();
    test_async_reset_mid_s2();
    test_random_safety();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
